// File: rtl/nonce_sched_pkg.sv
// Shared definitions for the nonce scheduler: FSM state encoding, datapath
// width, default watchdog limit and the packed job-result payload.
package nonce_sched_pkg;

    localparam int unsigned NONCE_W                = 32;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // Mutually exclusive job outcome flags
    typedef struct packed {
        logic found;
        logic exhausted;
        logic error;
    } job_result_t;

endpackage

// File: rtl/nonce_scheduler_if.sv
// Request/response channel between the nonce scheduler and the SHA-256 core.
//   master (scheduler): drives core_req, core_nonce; samples core_ack,
//                       core_done, core_hash_hi
//   slave  (core)     : the mirror image
interface nonce_scheduler_if;
    import nonce_sched_pkg::*;

    logic               core_req;
    logic [NONCE_W-1:0] core_nonce;
    logic               core_ack;
    logic               core_done;
    logic [NONCE_W-1:0] core_hash_hi;

    modport master (
        output core_req,
        output core_nonce,
        input  core_ack,
        input  core_done,
        input  core_hash_hi
    );

    modport slave (
        input  core_req,
        input  core_nonce,
        output core_ack,
        output core_done,
        output core_hash_hi
    );

endinterface

// File: rtl/nonce_scheduler_timeout.sv
// sched_timeout: per-nonce watchdog.
//   clk, reset : clock, async active-low reset
//   clear      : zero the count (held while not waiting on the core)
//   enable     : count one cycle spent waiting
//   expired    : high during the LIMIT-th enabled cycle since the last clear,
//                so the owner leaves its wait state exactly LIMIT cycles after
//                entering it
module sched_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Cycle counter, parks on LAST so it can never wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: walks a nonce range through an external SHA-256 core and
// stops at the first hash whose top word is <= target.
//   clk, reset            : clock, async active-low reset
//   start, abort          : job start pulse (IDLE only), job cancel
//   nonce_start/nonce_end : inclusive range, may wrap through 0xFFFFFFFF
//   target                : hit threshold (unsigned compare)
//   core                  : request/response channel to the hash core
//   busy, done            : job in progress, one-cycle end-of-job pulse
//   found/exhausted/error : job outcome, held until the next accepted start
//   found_nonce           : nonce that produced the hit
//   hash_count            : only with NONCE_SCHEDULER_STATS_EN, hashes checked
//                           in the current job (saturating)
module nonce_scheduler
    import nonce_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NONCE_W-1:0]   nonce_start,
    input  logic [NONCE_W-1:0]   nonce_end,
    input  logic [NONCE_W-1:0]   target,
    nonce_scheduler_if.master    core,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic                 exhausted,
    output logic                 error,
    output logic [NONCE_W-1:0]   found_nonce
`ifdef NONCE_SCHEDULER_STATS_EN
    ,
    output logic [NONCE_W-1:0]   hash_count
`endif
);

    sched_state_t       state_q, state_d;
    logic [NONCE_W-1:0] cur_q, cur_d;
    logic [NONCE_W-1:0] end_q, end_d;
    logic [NONCE_W-1:0] target_q, target_d;
    logic [NONCE_W-1:0] hash_q, hash_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    job_result_t        res_q, res_d;
    logic               core_req_q;
    logic               busy_q;
    logic               done_q;
    logic               start_ok;
    logic               to_expired;

    assign start_ok = (state_q == ST_IDLE) && start && !abort;

    // Watchdog runs only while waiting for core_done and is zero on entry
    sched_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_WAIT),
        .enable  (state_q == ST_WAIT),
        .expired (to_expired)
    );

    // State and datapath registers; handshake/status outputs follow next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            end_q         <= '0;
            target_q      <= '0;
            hash_q        <= '0;
            found_nonce_q <= '0;
            res_q         <= '0;
            core_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            end_q         <= end_d;
            target_q      <= target_d;
            hash_q        <= hash_d;
            found_nonce_q <= found_nonce_d;
            res_q         <= res_d;
            core_req_q    <= (state_d == ST_ISSUE);
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        end_d         = end_q;
        target_d      = target_q;
        hash_d        = hash_q;
        found_nonce_d = found_nonce_q;
        res_d         = res_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    cur_d         = nonce_start;
                    end_d         = nonce_end;
                    target_d      = target;
                    found_nonce_d = '0;
                    res_d         = '0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core.core_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result arriving in the expiry cycle still counts
                if (core.core_done) begin
                    hash_d  = core.core_hash_hi;
                    state_d = ST_CHECK;
                end else if (to_expired) begin
                    res_d.error = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_CHECK: begin
                if (hash_q <= target_q) begin
                    res_d.found   = 1'b1;
                    found_nonce_d = cur_q;
                    state_d       = ST_DONE;
                end else if (cur_q == end_q) begin
                    res_d.exhausted = 1'b1;
                    state_d         = ST_DONE;
                end else begin
                    // Natural 32-bit wrap handles ranges crossing zero
                    cur_d   = cur_q + NONCE_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cancel overrides everything outside IDLE and leaves no result behind
        if (abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            res_d         = '0;
            found_nonce_d = '0;
        end
    end

    assign core.core_req   = core_req_q;
    assign core.core_nonce = cur_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign found           = res_q.found;
    assign exhausted       = res_q.exhausted;
    assign error           = res_q.error;
    assign found_nonce     = found_nonce_q;

`ifdef NONCE_SCHEDULER_STATS_EN
    logic [NONCE_W-1:0] hash_cnt_q;

    // Counts WAIT->CHECK transitions of the current job, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hash_cnt_q <= '0;
        end else if (start_ok) begin
            hash_cnt_q <= '0;
        end else if ((state_q == ST_WAIT) && (state_d == ST_CHECK) && (hash_cnt_q != '1)) begin
            hash_cnt_q <= hash_cnt_q + NONCE_W'(1);
        end
    end

    assign hash_count = hash_cnt_q;
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Testbench for nonce_scheduler: a behavioural core responder, a range-walk
// reference model feeding expected nonces/results into queues, and monitors
// that pop and compare whenever the DUT hands a request or a done pulse out.
module tb_nonce_scheduler;
    import nonce_sched_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] nonce_start = '0;
    logic [31:0] nonce_end = '0;
    logic [31:0] target = '0;
    logic        busy, done, found, exhausted, error;
    logic [31:0] found_nonce;
`ifdef NONCE_SCHEDULER_STATS_EN
    logic [31:0] hash_count;
`endif

    always #5 clk = ~clk;

    nonce_scheduler_if bif();

    nonce_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target      (target),
        .core        (bif.master),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .exhausted   (exhausted),
        .error       (error),
        .found_nonce (found_nonce)
`ifdef NONCE_SCHEDULER_STATS_EN
        ,
        .hash_count  (hash_count)
`endif
    );

    typedef struct {
        logic        found;
        logic        exhausted;
        logic        error;
        logic [31:0] nonce;
    } res_t;

    logic [31:0] exp_nonce_q[$];
    res_t        exp_res_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_len = 0;
    int          req_count = 0;

    // Core behaviour knobs
    int          hash_mode = 0;
    logic [31:0] hit_nonce = 32'h0;
    logic [31:0] hit_hash = 32'h0;
    logic [31:0] salt = 32'h0;
    bit          core_hang = 1'b0;
    bit          late_done = 1'b0;
    bit          slow_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Hash the bench's core returns for a nonce
    function automatic logic [31:0] hash_of(input logic [31:0] n);
        if (hash_mode == 0) return (n == hit_nonce) ? hit_hash : 32'hFFFF_FFFF;
        return (n * 32'h9E37_79B1) ^ salt;
    endfunction

    // Reference: walk the inclusive (possibly wrapping) range until first hit
    task automatic model_job(input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] t, input bit hang);
        logic [31:0] n;
        res_t        r;
        int          cnt;
        r = '{1'b0, 1'b0, 1'b0, 32'h0};
        n = s;
        cnt = 0;
        if (hang) begin
            exp_nonce_q.push_back(s);
            cnt = 1;
            r.error = 1'b1;
        end else begin
            for (int i = 0; i < 4096; i++) begin
                exp_nonce_q.push_back(n);
                cnt++;
                if (hash_of(n) <= t) begin
                    r.found = 1'b1;
                    r.nonce = n;
                    break;
                end
                if (n == e) begin
                    r.exhausted = 1'b1;
                    break;
                end
                n = n + 32'd1;
            end
        end
        exp_res_q.push_back(r);
        exp_len = cnt;
    endtask

    // Behavioural SHA core: ack after 0-2 cycles, result after 0-2 more
    initial begin
        logic [31:0] n;
        bif.core_ack = 1'b0;
        bif.core_done = 1'b0;
        bif.core_hash_hi = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (bif.core_req === 1'b1) begin
                repeat (slow_ack ? 3 : $urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (bif.core_req !== 1'b1) continue;
                n = bif.core_nonce;
                bif.core_ack = 1'b1;
                req_count++;
                @(posedge clk); #1;
                bif.core_ack = 1'b0;
                if (!core_hang) begin
                    repeat (late_done ? 8 : $urandom_range(0, 2)) begin @(posedge clk); #1; end
                    bif.core_hash_hi = hash_of(n);
                    bif.core_done = 1'b1;
                    @(posedge clk); #1;
                    bif.core_done = 1'b0;
                    bif.core_hash_hi = $urandom;
                end
            end
        end
    end

    // Monitor: compares issued nonces and job results against the queues
    initial begin
        res_t r;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.core_req === 1'b1 && bif.core_ack === 1'b1) begin
                if (exp_nonce_q.size() == 0)
                    fail_now("unexpected_request", $sformatf("got nonce 0x%08h, required none", bif.core_nonce));
                else
                    chk("core_nonce", bif.core_nonce, exp_nonce_q.pop_front());
            end
            if (done === 1'b1) begin
                if (prev_done)
                    fail_now("done_width", "got done high two cycles running, required one");
                else if (exp_res_q.size() == 0)
                    fail_now("unexpected_done", "got done pulse, required none");
                else begin
                    r = exp_res_q.pop_front();
                    chk("found", 32'(found), 32'(r.found));
                    chk("exhausted", 32'(exhausted), 32'(r.exhausted));
                    chk("error", 32'(error), 32'(r.error));
                    if (r.found) chk("found_nonce", found_nonce, r.nonce);
                    chk("requests_left", 32'(exp_nonce_q.size()), 32'd0);
                end
            end
            prev_done = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] t, input bit ab);
        nonce_start = s;
        nonce_end = e;
        target = t;
        start = 1'b1;
        abort = ab;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int k;
        for (k = 0; k < max; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        if (k == max) fail_now("done_timeout", "got no done pulse, required one");
        tick(1);
    endtask

    task automatic wait_handshake(input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (bif.core_req === 1'b1 && bif.core_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("handshake_timeout", "got no core_req/core_ack, required one");
    endtask

    task automatic run_job(input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] t);
        model_job(s, e, t, 1'b0);
        req_count = 0;
        pulse_start(s, e, t, 1'b0);
        wait_done(400);
        chk("req_count", 32'(req_count), 32'(exp_len));
    endtask

    task automatic flush();
        exp_nonce_q.delete();
        exp_res_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running, required finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit ok;
        int k;
        logic [31:0] s, e, t;

        // Reset state
        tick(3);
        chk("rst_core_req", 32'(bif.core_req), 32'd0);
        chk("rst_core_nonce", bif.core_nonce, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", {29'd0, found, exhausted, error}, 32'd0);
        chk("rst_found_nonce", found_nonce, 32'd0);
        reset = 1'b1;
        tick(2);

        // Hit on 0x12 inside 0x10..0x13: three requests
        hash_mode = 0; hit_nonce = 32'h12; hit_hash = 32'h0000_00FF;
        run_job(32'h10, 32'h13, 32'h0000_0100);
        tick(3);
        chk("found_held", 32'(found), 32'd1);
        chk("found_nonce_held", found_nonce, 32'h12);
        chk("busy_after_job", 32'(busy), 32'd0);

        // Hash equal to target counts as a hit
        hit_nonce = 32'h21; hit_hash = 32'h0000_0100;
        run_job(32'h20, 32'h22, 32'h0000_0100);

        // Wrapping range, no hit
        hit_nonce = 32'h5000;
        run_job(32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0100);

        // Single-nonce range
        run_job(32'h77, 32'h77, 32'h0);

        // Core never answers: error TO cycles after WAIT entry
        core_hang = 1'b1;
        model_job(32'h30, 32'h40, 32'h0, 1'b1);
        req_count = 0;
        pulse_start(32'h30, 32'h40, 32'h0, 1'b0);
        wait_handshake(20, ok);
        if (ok) begin
            for (k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (done === 1'b1) break;
            end
            // handshake negedge precedes WAIT entry by half a cycle
            chk("timeout_latency", 32'(k), 32'(TO + 1));
        end
        tick(1);
        core_hang = 1'b0;
        tick(2);
        chk("timeout_error_held", 32'(error), 32'd1);

        // Abort during WAIT, then a late core_done
        late_done = 1'b1;
        model_job(32'h50, 32'h58, 32'h0, 1'b0);
        pulse_start(32'h50, 32'h58, 32'h0, 1'b0);
        wait_handshake(20, ok);
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_core_req", 32'(bif.core_req), 32'd0);
        chk("abort_flags", {29'd0, found, exhausted, error}, 32'd0);
        flush();
        tick(15);
        late_done = 1'b0;
        hit_nonce = 32'h63; hit_hash = 32'h0;
        run_job(32'h60, 32'h66, 32'h10);

        // Start while busy is ignored
        hit_nonce = 32'h5000;
        model_job(32'h100, 32'h105, 32'h0, 1'b0);
        req_count = 0;
        pulse_start(32'h100, 32'h105, 32'h0, 1'b0);
        tick(3);
        pulse_start(32'h500, 32'h500, 32'hFFFF_FFFF, 1'b0);
        wait_done(400);
        chk("busy_start_reqs", 32'(req_count), 32'(exp_len));

        // Start and abort together in IDLE: no job, previous result kept
        req_count = 0;
        pulse_start(32'h700, 32'h700, 32'hFFFF_FFFF, 1'b1);
        tick(6);
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_reqs", 32'(req_count), 32'd0);
        chk("start_abort_exhausted", 32'(exhausted), 32'd1);

        // Reset in the middle of ISSUE
        slow_ack = 1'b1;
        model_job(32'h200, 32'h203, 32'h0, 1'b0);
        pulse_start(32'h200, 32'h203, 32'h0, 1'b0);
        ok = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bif.core_req === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("issue_timeout", "got no core_req, required one");
        #1 reset = 1'b0;
        #1;
        chk("midrst_core_req", 32'(bif.core_req), 32'd0);
        chk("midrst_core_nonce", bif.core_nonce, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_outputs", {28'd0, done, found, exhausted, error}, 32'd0);
        flush();
        tick(2);
        reset = 1'b1;
        slow_ack = 1'b0;
        tick(12);

`ifdef NONCE_SCHEDULER_STATS_EN
        hash_mode = 0; hit_nonce = 32'h5000;
        run_job(32'h40, 32'h44, 32'h0);
        chk("hash_count", hash_count, 32'd5);
`endif

        // Randomized jobs against the reference model
        hash_mode = 1;
        for (int j = 0; j < 24; j++) begin
            salt = $urandom;
            s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            e = s + 32'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       t = 32'h0;
                1:       t = 32'hFFFF_FFFF;
                default: t = 32'($urandom_range(0, 32'h1FFF_FFFF));
            endcase
            run_job(s, e, t);
        end

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
